// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one external combinational Logic_unit between
// N_REQ requesters. It grants one request, drives the Logic_unit from
// registers, captures the result and returns it on a tagged response channel.
//
// Build option: define LU_ARB_RR_EN for round-robin arbitration. Leave it
// undefined for fixed priority (lowest index wins, no last_grant register).
module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [2*N_REQ-1:0] req_op,
  input  logic [W*N_REQ-1:0] req_x,
  input  logic [W*N_REQ-1:0] req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               lu_op1,
  output logic               lu_op0,
  output logic [W-1:0]       lu_x,
  output logic [W-1:0]       lu_y,
  input  logic [W-1:0]       lu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic           accept_ok;
  logic           accept;
  logic           win_found;
  logic [IDW-1:0] win_idx;

  logic [1:0]     sel_op;
  logic [W-1:0]   sel_x;
  logic [W-1:0]   sel_y;

`ifdef LU_ARB_RR_EN
  logic [IDW-1:0]     last_grant;
  logic [2*N_REQ-1:0] valid_dbl;
  logic [2*N_REQ-1:0] valid_rot;

  // Round-robin: rotate the valid vector so the search starts one past the
  // previous winner, then take the first set bit and map it back.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    valid_dbl = {req_valid, req_valid};
    valid_rot = valid_dbl >> (int'(last_grant) + 1);
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(last_grant) + 1 + i) % N_REQ);
      end
    end
  end

  // last_grant moves only when a request is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(N_REQ - 1);
    end else if (accept) begin
      last_grant <= win_idx;
    end
  end
`else
  // Fixed priority: lowest requester index with valid high wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end
`endif

  // Operand/opcode mux for the current winner.
  always_comb begin
    sel_op = '0;
    sel_x  = '0;
    sel_y  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_x  = req_x[W*i +: W];
        sel_y  = req_y[W*i +: W];
      end
    end
  end

  // A new request may be taken when idle, or in the same cycle the pending
  // response is handed off; reset suppresses every grant.
  always_comb begin
    accept_ok = (state == IDLE) || ((state == RESP) && rsp_ready);
    accept    = accept_ok && win_found && !rst;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (win_idx == IDW'(i));
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = accept ? EXEC : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0 -> p1: latch the granted request into the Logic_unit inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_op1 <= 1'b0;
      lu_op0 <= 1'b0;
      lu_x   <= '0;
      lu_y   <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      lu_op1 <= sel_op[1];
      lu_op0 <= sel_op[0];
      lu_x   <= sel_x;
      lu_y   <= sel_y;
      rsp_id <= win_idx;
    end
  end

  // Stage p1 -> p2: capture the Logic_unit result and hold it until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= lu_out;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: directed scenarios plus random traffic,
// checked by a transaction-level reference model and a response scoreboard.
module tb_logic_unit_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op = '0;
  logic [W*N-1:0]   req_x = '0;
  logic [W*N-1:0]   req_y = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_data;
  logic [IDW-1:0]   rsp_id;
  logic             lu_op1;
  logic             lu_op0;
  logic [W-1:0]     lu_x;
  logic [W-1:0]     lu_y;
  logic [W-1:0]     lu_out;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .lu_op1(lu_op1), .lu_op0(lu_op0), .lu_x(lu_x), .lu_y(lu_y),
    .lu_out(lu_out)
  );

  function automatic logic [W-1:0] lu_ref(input logic [1:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // External combinational Logic_unit.
  assign lu_out = lu_ref({lu_op1, lu_op0}, lu_x, lu_y);

  typedef struct packed {
    logic [W-1:0]   data;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state: outstanding operation and cycles since its accept.
  bit           m_out   = 1'b0;
  int           m_since = 100;
  logic [1:0]   m_op;
  logic [W-1:0] m_x;
  logic [W-1:0] m_y;
`ifdef LU_ARB_RR_EN
  int           m_lg = N - 1;
`endif

  function automatic int pick(input logic [N-1:0] v);
`ifdef LU_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (v[(m_lg + k) % N]) return (m_lg + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_cycle();
    int           w;
    logic         can;
    logic [N-1:0] exp_rdy;
    if (m_since < 100) m_since++;
    if (!rst) chk("rsp_valid", 64'(rsp_valid), 64'(m_out && m_since >= 2));
    if (!rst && m_out && m_since == 1)
      chk("lu_inputs", 64'({lu_op1, lu_op0, lu_x, lu_y}), 64'({m_op, m_x, m_y}));
    can = !rst && (!m_out || (m_since >= 2 && rsp_ready));
    w = pick(req_valid);
    exp_rdy = (can && w >= 0) ? (N'(1) << w) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
    if (rst) begin
      m_out   = 1'b0;
      m_since = 100;
      sb.delete();
`ifdef LU_ARB_RR_EN
      m_lg = N - 1;
`endif
    end else begin
      if (m_out && m_since >= 2 && rsp_ready) m_out = 1'b0;
      if (can && w >= 0) begin
        m_out   = 1'b1;
        m_since = 0;
        m_op    = req_op[2*w +: 2];
        m_x     = req_x[W*w +: W];
        m_y     = req_y[W*w +: W];
        sb.push_back({lu_ref(m_op, m_x, m_y), IDW'(w)});
`ifdef LU_ARB_RR_EN
        m_lg = w;
`endif
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic rr,
                      input logic [2*N-1:0] op, input logic [W*N-1:0] x,
                      input logic [W*N-1:0] y);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    rsp_ready = rr;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic rstep(input logic r, input logic [N-1:0] v, input logic rr);
    step(r, v, rr, 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks that
  // a stalled response does not change.
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic [IDW-1:0] prev_id;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rsp_valid && hold_prev) begin
        chk("stall_data", 64'(rsp_data), 64'(prev_data));
        chk("stall_id", 64'(rsp_id), 64'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id=%0d data=%h expected none", rsp_id, rsp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
        end
      end
    end
    hold_prev = (rst === 1'b0) && rsp_valid && !rsp_ready;
    prev_data = rsp_data;
    prev_id   = rsp_id;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0]   s_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [W-1:0] s_exp [4] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h0F0F};
  int           ord_exp[5];
  int           cnt3;

  initial begin
    // Reset and reset state.
    rstep(1, '1, 1);
    rstep(1, '0, 0);
    rstep(0, '0, 0);
    chk("reset_lu", 64'({lu_op1, lu_op0, lu_x, lu_y}), 64'(0));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    chk("reset_rsp_id", 64'(rsp_id), 64'(0));

    // Single request, each opcode.
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b0001, 1, {6'b0, s_op[k]}, {48'h0, 16'hF0F0}, {48'h0, 16'h3C3C});
      rstep(0, '0, 1);
      rstep(0, '0, 1);
      chk("single_data", 64'(rsp_data), 64'(s_exp[k]));
      chk("single_id", 64'(rsp_id), 64'(0));
      chk("single_valid", 64'(rsp_valid), 64'(1));
    end
    rstep(0, '0, 1);

    // All requesters valid, consumer always ready.
    rstep(1, '0, 1);
    glog.delete();
    for (int c = 0; c < 10; c++) rstep(0, 4'b1111, 1);
`ifdef LU_ARB_RR_EN
    ord_exp = '{0, 1, 2, 3, 0};
`else
    ord_exp = '{0, 0, 0, 0, 0};
`endif
    chk("order_len", 64'(glog.size()), 64'(5));
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("order", 64'(glog[i]), 64'(ord_exp[i]));
    for (int c = 0; c < 3; c++) rstep(0, '0, 1);

    // Backpressure with requesters 1 and 2 waiting.
    rstep(0, 4'b0110, 0);
    rstep(0, 4'b0110, 0);
    for (int c = 0; c < 5; c++) rstep(0, 4'b0110, 0);
    rstep(0, 4'b0110, 1);
`ifdef LU_ARB_RR_EN
    chk("bp_regrant", 64'(req_ready), 64'(4'b0100));
`else
    chk("bp_regrant", 64'(req_ready), 64'(4'b0010));
`endif
    for (int c = 0; c < 3; c++) rstep(0, '0, 1);

    // Reset while in EXEC.
    rstep(0, 4'b0100, 1);
    rstep(1, '0, 1);
    rstep(0, '0, 1);
    chk("rst_exec_lu", 64'({lu_op1, lu_op0, lu_x, lu_y}), 64'(0));
    chk("rst_exec_data", 64'(rsp_data), 64'(0));
    rstep(0, 4'b1111, 1);
    chk("rst_next_grant", 64'(req_ready), 64'(4'b0001));
    for (int c = 0; c < 3; c++) rstep(0, '0, 1);

    // Requester 3 pulses only while a response is stalled.
    glog.delete();
    rstep(0, 4'b0010, 0);
    rstep(0, '0, 0);
    rstep(0, 4'b1000, 0);
    rstep(0, '0, 0);
    rstep(0, '0, 1);
    rstep(0, '0, 1);
    cnt3 = 0;
    foreach (glog[i]) if (glog[i] == 3) cnt3++;
    chk("withdraw_no3", 64'(cnt3), 64'(0));

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      rstep(($urandom_range(0, 199) == 0), N'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 4; c++) rstep(0, '0, 1);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
